// File: rtl/tl_updown_counter_pkg.sv
// Shared constants for the traffic-light phase timer and related timing generators.
package tl_counter_pkg;

    // Direction and boundary-behaviour encodings for the mode / wrap_en inputs.
    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;
    localparam logic WRAP      = 1'b1;
    localparam logic SAT       = 1'b0;

    // Default timer geometry, shared with the traffic-light FSM.
    localparam int TL_CNT_WIDTH = 5;
    localparam int TL_CNT_MAX   = 30;

endpackage : tl_counter_pkg

// File: rtl/tl_updown_counter_if.sv
// Control/status bundle of the up/down counter: the controller drives the strobes
// and mode bits, and the counter returns its count and pulses.
interface tl_updown_counter_if
    import tl_counter_pkg::*;
#(
    parameter int WIDTH = TL_CNT_WIDTH
);
    logic             en;
    logic             mode;
    logic             wrap_en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] counter;
    logic             tc;
    logic             step;

    modport master (
        output en, mode, wrap_en, load, load_val,
        input  counter, tc, step
    );

    modport slave (
        input  en, mode, wrap_en, load, load_val,
        output counter, tc, step
    );
endinterface : tl_updown_counter_if

// File: rtl/tl_updown_counter_prescaler.sv
// Clock-enable prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// The phase freezes while en_i is low and restarts from zero on clr_i.
module tl_tick_prescaler #(
    parameter int PRESCALE = 1,
    parameter int PS_W     = $clog2(PRESCALE + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    logic [PS_W-1:0] ps_cnt_q;
    logic [PS_W-1:0] ps_cnt_d;

    // The tick is combinational so the owner sees it in the same cycle the phase wraps.
    assign tick_o = en_i && (ps_cnt_q == PS_W'(PRESCALE - 1));

    // Next prescaler phase: clear wins, otherwise advance only while enabled.
    always_comb begin
        // NOTE: default assignment first, so every path drives ps_cnt_d and no latch is inferred.
        ps_cnt_d = ps_cnt_q;
        if (clr_i) begin
            ps_cnt_d = '0;
        end else if (en_i) begin
            ps_cnt_d = tick_o ? '0 : ps_cnt_q + PS_W'(1);
        end
    end

    // Phase register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
        if (!rst_n) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end
endmodule : tl_tick_prescaler

// File: rtl/tl_updown_counter.sv
// Parametrised up/down counter with prescaler, parallel load, wrap/saturate
// boundaries and a registered terminal-count pulse.
module tl_updown_counter
    import tl_counter_pkg::*;
#(
    parameter int  WIDTH    = TL_CNT_WIDTH,
    parameter int  MAX_VAL  = TL_CNT_MAX,
    parameter int  PRESCALE = 1,
    localparam int PS_W     = $clog2(PRESCALE + 1)
) (
    input logic               clk,
    input logic               rst_n,
    tl_updown_counter_if.slave bus
);
    // Reject illegal geometries at elaboration rather than building a broken counter.
    if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
        $error("tl_updown_counter: MAX_VAL=%0d outside 1..2^WIDTH-1", MAX_VAL);
    end
    if (PRESCALE < 1) begin : g_bad_ps
        $error("tl_updown_counter: PRESCALE=%0d must be >= 1", PRESCALE);
    end

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic             step_int;
    logic             at_max;
    logic             at_zero;
    logic             at_bound;
    logic [WIDTH-1:0] load_clip;

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             tc_q, tc_d;
    logic             step_q, step_d;

    // A load restarts the prescale period so the first step after it is a full period away.
    tl_tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (bus.en),
        .clr_i  (bus.load),
        .tick_o (step_int)
    );

    // Boundary compares; wrap uses these rather than relying on natural overflow.
    assign at_max    = (counter_q == MAX_C);
    assign at_zero   = (counter_q == '0);
    assign at_bound  = (bus.mode == MODE_UP) ? at_max : at_zero;
    assign load_clip = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;

    // Next count and pulses: load beats step beats hold.
    always_comb begin
        counter_d = counter_q;
        tc_d      = 1'b0;
        step_d    = step_int;
        if (bus.load) begin
            counter_d = load_clip;
        end else if (step_int) begin
            tc_d = at_bound;
            if (bus.mode == MODE_UP) begin
                if (!at_max)                 counter_d = counter_q + WIDTH'(1);
                else if (bus.wrap_en == WRAP) counter_d = '0;
            end else begin
                if (!at_zero)                counter_d = counter_q - WIDTH'(1);
                else if (bus.wrap_en == WRAP) counter_d = MAX_C;
            end
        end
    end

    // Count, terminal-count and step registers, all cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
            tc_q      <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            tc_q      <= tc_d;
            step_q    <= step_d;
        end
    end

    assign bus.counter = counter_q;
    assign bus.tc      = tc_q;
    assign bus.step    = step_q;
endmodule : tl_updown_counter

// File: tb/tb_tl_updown_counter.sv
// Scoreboard bench for tl_updown_counter: one instance with PRESCALE=1 and one
// with PRESCALE=4, both MAX_VAL=30. Stimulus pushes hand-computed expectations;
// a separate monitor pops and compares after each clock or reset event.
module tb_tl_updown_counter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    tl_updown_counter_if #(.WIDTH(5)) b1 ();
    tl_updown_counter_if #(.WIDTH(5)) b4 ();

    tl_updown_counter #(.WIDTH(5), .MAX_VAL(30), .PRESCALE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    tl_updown_counter #(.WIDTH(5), .MAX_VAL(30), .PRESCALE(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    typedef struct {
        bit         sel;   // 1 = PRESCALE=1 instance, 0 = PRESCALE=4 instance
        logic [4:0] cnt;
        logic       tc;
        logic       step;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: after every clock edge or reset assertion, check everything queued for it.
    initial begin
        exp_t       e;
        logic [4:0] a_cnt;
        logic       a_tc;
        logic       a_step;
        forever begin
            @(posedge clk or negedge rst_n);
            #2;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.sel) begin
                    a_cnt = b1.counter; a_tc = b1.tc; a_step = b1.step;
                end else begin
                    a_cnt = b4.counter; a_tc = b4.tc; a_step = b4.step;
                end
                n_tests++;
                if (a_cnt !== e.cnt || a_tc !== e.tc || a_step !== e.step) begin
                    n_fail++;
                    $display("FAIL %s (ps%0d): got cnt=%0d tc=%b step=%b, expected cnt=%0d tc=%b step=%b",
                             e.name, e.sel ? 1 : 4, a_cnt, a_tc, a_step, e.cnt, e.tc, e.step);
                end
            end
        end
    end

    // One clock of stimulus on the selected instance plus the expected result of that edge.
    task automatic cyc(input bit sel, input bit en, input bit mode, input bit wrap,
                       input bit load, input logic [4:0] lv,
                       input logic [4:0] ec, input bit et, input bit es, input string nm);
        @(negedge clk);
        if (sel) begin
            b1.en = en; b1.mode = mode; b1.wrap_en = wrap; b1.load = load; b1.load_val = lv;
        end else begin
            b4.en = en; b4.mode = mode; b4.wrap_en = wrap; b4.load = load; b4.load_val = lv;
        end
        sb_q.push_back('{sel, ec, et, es, nm});
        @(posedge clk);
    endtask

    // Assert reset mid-cycle; both instances must clear before the next clock edge.
    task automatic async_reset(input string nm);
        #3;
        sb_q.push_back('{1'b1, 5'd0, 1'b0, 1'b0, nm});
        sb_q.push_back('{1'b0, 5'd0, 1'b0, 1'b0, nm});
        rst_n = 1'b0;
        @(negedge clk);
        b1.en = 1'b0; b1.load = 1'b0;
        b4.en = 1'b0; b4.load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        b1.en = 1'b0; b1.mode = 1'b0; b1.wrap_en = 1'b0; b1.load = 1'b0; b1.load_val = '0;
        b4.en = 1'b0; b4.mode = 1'b0; b4.wrap_en = 1'b0; b4.load = 1'b0; b4.load_val = '0;

        // Power-on reset.
        @(posedge clk);
        async_reset("reset");

        // 1: count up with wrap, 0..30 then back to 0 with a tc pulse.
        for (int i = 1; i <= 31; i++)
            cyc(1, 1, 1, 1, 0, 5'd0, 5'(i % 31), (i == 31), 1, "t1_up_wrap");
        cyc(1, 0, 1, 1, 0, 5'd0, 5'd0, 0, 0, "t1_hold");

        // 2: down with wrap from 0.
        cyc(1, 1, 0, 1, 0, 5'd0, 5'd30, 1, 1, "t2_down_wrap");
        cyc(1, 1, 0, 1, 0, 5'd0, 5'd29, 0, 1, "t2_down");
        cyc(1, 0, 0, 1, 0, 5'd0, 5'd29, 0, 0, "t2_hold");

        // 3: saturate up from a load of 28.
        cyc(1, 0, 1, 0, 1, 5'd28, 5'd28, 0, 0, "t3_load");
        cyc(1, 1, 1, 0, 0, 5'd0,  5'd29, 0, 1, "t3_step1");
        cyc(1, 1, 1, 0, 0, 5'd0,  5'd30, 0, 1, "t3_step2");
        cyc(1, 1, 1, 0, 0, 5'd0,  5'd30, 1, 1, "t3_step3");
        cyc(1, 1, 1, 0, 0, 5'd0,  5'd30, 1, 1, "t3_step4");
        cyc(1, 0, 1, 0, 0, 5'd0,  5'd30, 0, 0, "t3_idle");

        // 5: load beats a coincident step at the wrap boundary and clips to MAX_VAL.
        cyc(1, 1, 1, 1, 1, 5'd31, 5'd30, 0, 1, "t5_load_clip");
        cyc(1, 0, 1, 1, 1, 5'd5,  5'd5,  0, 0, "t5_load_noen");
        cyc(1, 1, 1, 1, 0, 5'd0,  5'd6,  0, 1, "mode_up");
        cyc(1, 1, 0, 1, 0, 5'd0,  5'd5,  0, 1, "mode_down");

        // Saturate down at 0.
        cyc(1, 0, 0, 0, 1, 5'd1, 5'd1, 0, 0, "sat0_load");
        cyc(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 1, "sat0_step1");
        cyc(1, 1, 0, 0, 0, 5'd0, 5'd0, 1, 1, "sat0_step2");
        cyc(1, 0, 0, 0, 1, 5'd30, 5'd30, 0, 0, "load_max");

        // 4: PRESCALE=4 advances once every four enabled cycles.
        for (int k = 1; k <= 10; k++)
            cyc(0, 1, 1, 1, 0, 5'd0, 5'(k / 4), 0, ((k % 4) == 0), "t4_prescale");
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 1, 1, 0, 5'd0, 5'd2, 0, 0, "t4_en_off");
        cyc(0, 1, 1, 1, 0, 5'd0, 5'd2, 0, 0, "t4_resume");
        cyc(0, 1, 1, 1, 0, 5'd0, 5'd3, 0, 1, "t4_step");

        // 5 with prescaler: a load clears the phase, so the next step is a full period away.
        cyc(0, 1, 1, 1, 0, 5'd0,  5'd3,  0, 0, "t5p_phase");
        cyc(0, 1, 1, 1, 1, 5'd31, 5'd30, 0, 0, "t5p_load");
        for (int k = 0; k < 3; k++)
            cyc(0, 1, 1, 1, 0, 5'd0, 5'd30, 0, 0, "t5p_wait");
        cyc(0, 1, 1, 1, 0, 5'd0, 5'd0, 1, 1, "t5p_wrap");

        // 6: reset right after a step edge, then mid-period with counter=17.
        cyc(0, 0, 1, 1, 1, 5'd16, 5'd16, 0, 0, "t6_load");
        for (int k = 1; k <= 4; k++)
            cyc(0, 1, 1, 1, 0, 5'd0, (k == 4) ? 5'd17 : 5'd16, 0, (k == 4), "t6_count");
        async_reset("t6_reset_step");
        cyc(0, 0, 1, 1, 1, 5'd17, 5'd17, 0, 0, "t6_reload");
        cyc(0, 1, 1, 1, 0, 5'd0,  5'd17, 0, 0, "t6_mid1");
        cyc(0, 1, 1, 1, 0, 5'd0,  5'd17, 0, 0, "t6_mid2");
        async_reset("t6_reset_mid");
        for (int k = 1; k <= 4; k++)
            cyc(0, 1, 1, 1, 0, 5'd0, (k == 4) ? 5'd1 : 5'd0, 0, (k == 4), "t6_full_period");

        // Drain the scoreboard; anything left unchecked is a failure.
        repeat (3) @(posedge clk);
        #3;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule : tb_tl_updown_counter

// File: doc/tl_updown_counter.md
Name: tl_updown_counter

Overview:
Parametrised synchronous up/down counter for the traffic-light FSM and other timing generators. It generalises the fixed 5-bit 0..30 counter in three ways: configurable width and terminal value, a built-in clock-enable prescaler, and parallel load. It supports both wrap and saturate modes and emits a registered terminal-count pulse. The FSM uses it as its phase timer and reacts to `tc`.

Parameters:
- WIDTH, 5, counter width in bits.
- MAX_VAL, 30, terminal value. Legal range 1..2^WIDTH-1; checked at elaboration with $error.
- PRESCALE, 1, clk cycles per count step. 1 means step every enabled cycle. Legal ≥ 1.
- PS_W, $clog2(PRESCALE+1), prescaler counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  count enable; freezes counter and prescaler when 0
- mode  in  1  1 = count up toward MAX_VAL, 0 = count down toward 0
- wrap_en  in  1  1 = wrap at boundary, 0 = saturate at boundary
- load  in  1  synchronous parallel load strobe
- load_val  in  WIDTH  value to load
- counter  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered, one cycle)
- step  out  1  registered copy of the internal step strobe (debug/chaining)

Behaviour:
- Reset (rst_n=0, async):
  - counter=0, tc=0, step=0, prescaler count=0.
  - Takes effect immediately and overrides everything, including mid-load or mid-prescale.
- Prescaler:
  - ps_cnt increments on each clk with en=1.
  - When ps_cnt==PRESCALE-1 and en=1, step_int=1 for that cycle and ps_cnt returns to 0.
  - PRESCALE=1 gives step_int=en.
  - en=0 holds ps_cnt.
- Priority per clock edge: reset > load > step > hold.
- Load (load=1):
  - counter <= min(load_val, MAX_VAL); ps_cnt <= 0; tc <= 0.
  - Load applies regardless of en.
  - A step coincident with load is discarded.
- Step with mode=1:
  - counter<MAX_VAL: counter+1.
  - counter==MAX_VAL: wrap_en=1 gives 0, wrap_en=0 holds MAX_VAL.
- Step with mode=0:
  - counter>0: counter-1.
  - counter==0: wrap_en=1 gives MAX_VAL, wrap_en=0 holds 0.
- tc:
  - Asserts for exactly the cycle after any step taken while counter is at the boundary for the current direction (MAX_VAL when up, 0 when down).
  - This covers both the wrap case and the saturate-hold case.
  - While saturated with steps continuing, tc pulses once per step.
  - Deasserts on any cycle without such a step.
- step output: registered step_int, aligned with the counter update.
- mode and wrap_en are sampled at each step edge.
  - Changing them between steps affects the next step only.
  - No glitch, and the current value is preserved.
- Arithmetic is WIDTH bits and unsigned. The counter never leaves 0..MAX_VAL; no other value is reachable.
- With MAX_VAL = 2^WIDTH-1, wrap must still be an explicit compare, not natural overflow.
- Latency: counter reflects a load or step one clk after the strobe edge; tc and step are coincident with that update.

Decomposition:
- Package tl_counter_pkg:
  - localparam MODE_DOWN=1'b0, MODE_UP=1'b1, WRAP=1'b1, SAT=1'b0.
  - Default WIDTH and MAX_VAL constants shared with the traffic-light FSM.
- One sub-module, tl_tick_prescaler (PRESCALE parameter; clk, rst_n, en, clr → tick).
  - clr is driven by load.
  - Reusable by the FSM for its blink timer.
- Counter and tc logic stay in the top module as a single always block plus boundary compares.

Test Plan:
1. Reset, then mode=1, wrap_en=1, en=1, PRESCALE=1, MAX_VAL=30 for 31 cycles.
   - counter goes 0..30, then 0.
   - tc high for one cycle exactly when counter shows 0 after 30.
2. From 0 with mode=0, wrap_en=1, one step → counter=30, tc=1; the next step → 29, tc=0.
3. Saturate, mode=1, wrap_en=0, load_val=28.
   - After load, 4 steps → 29, 30, 30, 30.
   - tc high on the 3rd and 4th steps only.
4. PRESCALE=4:
   - Counter advances once every 4 enabled cycles.
   - Deassert en for 3 cycles mid-period: prescale phase is held, and the next step occurs after the remaining cycles.
5. Load priority:
   - load=1 with load_val=31 (>MAX_VAL) on a step cycle → counter=30, tc=0, ps_cnt cleared.
   - Load with en=0 still applies.
6. Async reset mid-count (counter=17, during a prescale period) → counter=0, tc=0, step=0 immediately, not on the next clk.
   - Counting resumes from 0 with a full prescale period after rst_n rises.
